// File: rtl/cpu_pkg.sv
// Shared processor-wide constants and types for the stream merge datapath.
package cpu_pkg;

  localparam int   DATA_W = 16;
  localparam logic SRC_A  = 1'b0;
  localparam logic SRC_B  = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } q_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: purely combinational, the last-grant history is held by the parent.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt[SRC_A] = 1'b1;
        2'b10:   gnt[SRC_B] = 1'b1;
        // Contested slot goes to whichever source did not win last time.
        2'b11:   gnt = (last_grant == SRC_A) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Merges two valid/ready word streams into one through a single-entry output register,
// tagging each word with its source and arbitrating contested slots round-robin.
module mux2_stream_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic              q_sel,
  input  logic              q_ready
);

  q_state_e   state_q;
  q_state_e   state_d;
  logic       last_grant;
  logic       load_en;
  logic       accept;
  logic [1:0] gnt;

  assign q_valid = (state_q == FULL);
  assign load_en = !q_valid || q_ready;

  // Arbitration is suppressed during reset so no handshake can complete in that cycle.
  rr_arbiter2 u_arb (
    .req        ({b_valid, a_valid}),
    .last_grant (last_grant),
    .en         (load_en && !rst),
    .gnt        (gnt)
  );

  assign a_ready = gnt[SRC_A];
  assign b_ready = gnt[SRC_B];
  assign accept  = |gnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (q_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output register stage: loads on accept, otherwise holds the current word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      last_grant <= SRC_B;
      q_data     <= '0;
      q_sel      <= SRC_A;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant <= gnt[SRC_B];
        q_sel      <= gnt[SRC_B];
        q_data     <= gnt[SRC_B] ? b_data : a_data;
      end
    end
  end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Self-checking bench for mux2_stream_arbiter: directed scenarios plus a randomized run
// checked against a rule-level reference model.
module tb_mux2_stream_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, q_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, q_valid, q_sel;
  logic [W-1:0] q_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux2_stream_arbiter #(.DATA_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .q_valid (q_valid),
    .q_data  (q_data),
    .q_sel   (q_sel),
    .q_ready (q_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    q_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; q_ready = 1'b1;
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready});
    end
    tick();
    vectors++;
    if ({q_valid, q_sel, q_data} !== {1'b0, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b s=%b d=%h expected v=0 s=0 d=0000", q_valid, q_sel, q_data);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1'b1; a_data = 16'h1234; q_ready = 1'b1;
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 10", {a_ready, b_ready});
    end
    tick();
    a_valid = 1'b0;
    vectors++;
    if ({q_valid, q_sel, q_data} !== {1'b1, 1'b0, 16'h1234}) begin
      miscompares++;
      $display("FAIL single_out: got v=%b s=%b d=%h expected v=1 s=0 d=1234", q_valid, q_sel, q_data);
    end
    tick();
    vectors++;
    if (q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got q_valid=%b expected 0", q_valid);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    a_valid = 1'b1; a_data = 16'hAAAA;
    b_valid = 1'b1; b_data = 16'hBBBB;
    q_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic         es;
      logic [W-1:0] ed;
      es = i[0];
      ed = es ? 16'hBBBB : 16'hAAAA;
      #1;
      vectors++;
      if ({a_ready, b_ready} !== {!es, es}) begin
        miscompares++;
        $display("FAIL alt_ready[%0d]: got %b expected %b", i, {a_ready, b_ready}, {!es, es});
      end
      tick();
      vectors++;
      if ({q_valid, q_sel, q_data} !== {1'b1, es, ed}) begin
        miscompares++;
        $display("FAIL alt_out[%0d]: got v=%b s=%b d=%h expected v=1 s=%b d=%h", i, q_valid, q_sel, q_data, es, ed);
      end
    end
    idle_inputs();
    q_ready = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    a_valid = 1'b1; a_data = 16'h5555; q_ready = 1'b1;
    tick();
    q_ready = 1'b0; a_data = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({a_ready, b_ready} !== 2'b00) begin
        miscompares++;
        $display("FAIL stall_ready[%0d]: got %b expected 00", i, {a_ready, b_ready});
      end
      tick();
      vectors++;
      if ({q_valid, q_data} !== {1'b1, 16'h5555}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h expected v=1 d=5555", i, q_valid, q_data);
      end
    end
    q_ready = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %b expected 1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    q_ready = 1'b0;
    vectors++;
    if ({q_valid, q_data} !== {1'b1, 16'h7777}) begin
      miscompares++;
      $display("FAIL stall_new_word: got v=%b d=%h expected v=1 d=7777", q_valid, q_data);
    end
  endtask

  task automatic test_back_to_back();
    // Entered with the register still holding 16'h7777.
    q_ready = 1'b1; b_valid = 1'b1; b_data = 16'h00FF;
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_ready: got %b expected 01", {a_ready, b_ready});
    end
    tick();
    b_valid = 1'b0;
    vectors++;
    if ({q_valid, q_sel, q_data} !== {1'b1, 1'b1, 16'h00FF}) begin
      miscompares++;
      $display("FAIL b2b_out: got v=%b s=%b d=%h expected v=1 s=1 d=00ff", q_valid, q_sel, q_data);
    end
    tick();
    vectors++;
    if (q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got q_valid=%b expected 0", q_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    b_valid = 1'b1; b_data = 16'h0B0B; q_ready = 1'b1;
    tick();
    a_valid = 1'b1; a_data = 16'h0A0A;
    rst = 1'b1;
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_ready: got %b expected 00", {a_ready, b_ready});
    end
    tick();
    rst = 1'b0;
    vectors++;
    if (q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_discard: got q_valid=%b expected 0", q_valid);
    end
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid_tie: got %b expected 10", {a_ready, b_ready});
    end
    tick();
    vectors++;
    if ({q_valid, q_sel, q_data} !== {1'b1, 1'b0, 16'h0A0A}) begin
      miscompares++;
      $display("FAIL rstmid_first: got v=%b s=%b d=%h expected v=1 s=0 d=0a0a", q_valid, q_sel, q_data);
    end
    idle_inputs();
    q_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic         m_valid, m_sel, m_last;
    logic [W-1:0] m_data;
    int           exp_src;
    int           a_sent, b_sent, a_seen, b_seen;
    do_reset();
    m_valid = 1'b0; m_sel = 1'b0; m_data = '0; m_last = 1'b1;
    a_sent = 0; b_sent = 0; a_seen = 0; b_seen = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Sources keep a word until accepted, then may present a fresh one.
      if (!a_valid && $urandom_range(0, 99) < 60) begin
        a_valid = 1'b1; a_data = W'($urandom);
      end
      if (!b_valid && $urandom_range(0, 99) < 60) begin
        b_valid = 1'b1; b_data = W'($urandom);
      end
      q_ready = ($urandom_range(0, 99) < 65);
      rst     = ($urandom_range(0, 99) < 2);
      exp_src = -1;
      if (!rst && (!m_valid || q_ready)) begin
        if (a_valid && b_valid) exp_src = (m_last == 1'b0) ? 1 : 0;
        else if (a_valid)       exp_src = 0;
        else if (b_valid)       exp_src = 1;
      end
      #1;
      vectors++;
      if ({a_ready, b_ready} !== {exp_src == 0, exp_src == 1}) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, {a_ready, b_ready},
                 {exp_src == 0, exp_src == 1});
      end
      if (rst) begin
        m_valid = 1'b0; m_sel = 1'b0; m_data = '0; m_last = 1'b1;
      end else begin
        if (m_valid && q_ready) begin
          if (m_sel) b_seen++; else a_seen++;
        end
        if (exp_src >= 0) begin
          m_valid = 1'b1;
          m_sel   = (exp_src == 1);
          m_data  = (exp_src == 1) ? b_data : a_data;
          m_last  = m_sel;
        end else if (q_ready) begin
          m_valid = 1'b0;
        end
      end
      tick();
      if (exp_src == 0) begin a_valid = 1'b0; a_sent++; end
      if (exp_src == 1) begin b_valid = 1'b0; b_sent++; end
      vectors++;
      if (q_valid !== m_valid || (m_valid && {q_sel, q_data} !== {m_sel, m_data})) begin
        miscompares++;
        $display("FAIL rand_out[%0d]: got v=%b s=%b d=%h expected v=%b s=%b d=%h", cyc,
                 q_valid, q_sel, q_data, m_valid, m_sel, m_data);
      end
    end
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; q_ready = 1'b1;
    tick();
    vectors++;
    if (a_sent + b_sent < 50) begin
      miscompares++;
      $display("FAIL rand_traffic: got %0d accepts expected at least 50", a_sent + b_sent);
    end
    // Every accepted word is drained exactly once unless a reset discarded it.
    vectors++;
    if (a_seen > a_sent || b_seen > b_sent) begin
      miscompares++;
      $display("FAIL rand_conservation: got drained a=%0d b=%0d exceeding accepted a=%0d b=%0d",
               a_seen, b_seen, a_sent, b_sent);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
